// File: rtl/muxn_sync.sv
// muxn_sync: N-channel registered multiplexer with deferred source switching.
//
// A channel-select request is captured into a pending register and only
// becomes the active select on an update strobe, typically frame start or
// vsync. Sources in the pixel path therefore switch cleanly at a frame
// boundary. The selected channel feeds an output register that has a hold
// enable.
//
// Parameters:
//   WIDTH - data width per channel
//   N     - number of input channels (2..16, need not be a power of two)
//   SELW  - select width, 2**SELW >= N
//
// Ports:
//   i_clk   - system clock, rising edge
//   i_rst_n - asynchronous active-low reset
//   i_d     - flattened channel data, channel k at [k*WIDTH +: WIDTH]
//   i_s     - requested channel index
//   i_req   - select-request strobe, i_s sampled when high
//   i_upd   - update strobe, pending select becomes active
//   i_en    - output register enable
//   o_y     - registered selected data
//   o_sel   - currently active channel
//   o_pend  - a request is pending
//   o_err   - one-cycle pulse on an out-of-range request
module muxn_sync #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N*WIDTH-1:0] i_d,
  input  logic [SELW-1:0]    i_s,
  input  logic               i_req,
  input  logic               i_upd,
  input  logic               i_en,
  output logic [WIDTH-1:0]   o_y,
  output logic [SELW-1:0]    o_sel,
  output logic               o_pend,
  output logic               o_err
);

  // One extra bit so that N itself is representable when N == 2**SELW.
  localparam logic [SELW:0] NUM_CH = (SELW+1)'(N);

  logic [SELW-1:0]  pend_sel;
  logic             s_valid;
  logic [WIDTH-1:0] sel_data;

  assign s_valid = ({1'b0, i_s} < NUM_CH);

  // Channel picked by a compare loop rather than a variable part-select, so a
  // non-power-of-two N never produces an out-of-range slice.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (o_sel == SELW'(k)) begin
        sel_data = i_d[k*WIDTH +: WIDTH];
      end
    end
  end

  // Select control. A valid request arriving together with an update bypasses
  // the pending register. An invalid request never touches pending state, so
  // an update in the same cycle still commits the older pending value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_sel <= '0;
      o_pend   <= 1'b0;
      o_sel    <= '0;
      o_err    <= 1'b0;
    end else begin
      o_err <= i_req && !s_valid;
      if (i_req && i_upd && s_valid) begin
        o_sel  <= i_s;
        o_pend <= 1'b0;
      end else if (i_upd && o_pend) begin
        o_sel  <= pend_sel;
        o_pend <= 1'b0;
      end else if (i_req && s_valid) begin
        pend_sel <= i_s;
        o_pend   <= 1'b1;
      end
    end
  end

  // Output register. It uses the select held before this edge, so a switch
  // appears on o_y one edge after o_sel changes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_y <= '0;
    end else if (i_en) begin
      o_y <= sel_data;
    end
  end

endmodule

// File: tb/tb_muxn_sync.sv
// tb_muxn_sync: directed self-checking bench for muxn_sync.
// Two instances share clock, reset and enable. dut uses the default N=4.
// dut3 uses N=3, so that select value 3 is out of range.
module tb_muxn_sync;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [127:0] d;
  logic [1:0]   s;
  logic         req, upd;
  logic [31:0]  y;
  logic [1:0]   sel;
  logic         pend, err;

  logic [95:0]  d3;
  logic [1:0]   s3;
  logic         req3, upd3;
  logic [31:0]  y3;
  logic [1:0]   sel3;
  logic         pend3, err3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muxn_sync #(.WIDTH(32), .N(4), .SELW(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_d(d), .i_s(s), .i_req(req), .i_upd(upd),
    .i_en(en), .o_y(y), .o_sel(sel), .o_pend(pend), .o_err(err)
  );

  muxn_sync #(.WIDTH(32), .N(3), .SELW(2)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_d(d3), .i_s(s3), .i_req(req3), .i_upd(upd3),
    .i_en(en), .o_y(y3), .o_sel(sel3), .o_pend(pend3), .o_err(err3)
  );

  // Advance one rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    d  = {32'h44, 32'h33, 32'h22, 32'h11};
    d3 = {32'h33, 32'h22, 32'h11};
    s = 2'd0; req = 1'b0; upd = 1'b0;
    s3 = 2'd0; req3 = 1'b0; upd3 = 1'b0;
    step(); step();
    checks++; if (y !== 32'h0) begin errors++; $display("[TB] FAIL reset_y got %h exp %h", y, 32'h0); end
    checks++; if (sel !== 2'd0) begin errors++; $display("[TB] FAIL reset_sel got %0d exp 0", sel); end
    checks++; if (pend !== 1'b0) begin errors++; $display("[TB] FAIL reset_pend got %b exp 0", pend); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b exp 0", err); end
    checks++; if (y3 !== 32'h0) begin errors++; $display("[TB] FAIL reset_y3 got %h exp %h", y3, 32'h0); end
    rst_n = 1'b1;
    step();
    checks++; if (y !== 32'h11) begin errors++; $display("[TB] FAIL release_y got %h exp %h", y, 32'h11); end
    checks++; if (y3 !== 32'h11) begin errors++; $display("[TB] FAIL release_y3 got %h exp %h", y3, 32'h11); end
  endtask

  task automatic test_deferred();
    req = 1'b1; s = 2'd2;
    step();
    req = 1'b0;
    checks++; if (pend !== 1'b1) begin errors++; $display("[TB] FAIL defer_pend got %b exp 1", pend); end
    checks++; if (sel !== 2'd0) begin errors++; $display("[TB] FAIL defer_sel got %0d exp 0", sel); end
    checks++; if (y !== 32'h11) begin errors++; $display("[TB] FAIL defer_y got %h exp %h", y, 32'h11); end
    upd = 1'b1;
    step();
    upd = 1'b0;
    checks++; if (sel !== 2'd2) begin errors++; $display("[TB] FAIL upd_sel got %0d exp 2", sel); end
    checks++; if (pend !== 1'b0) begin errors++; $display("[TB] FAIL upd_pend got %b exp 0", pend); end
    checks++; if (y !== 32'h11) begin errors++; $display("[TB] FAIL upd_y_lat got %h exp %h", y, 32'h11); end
    step();
    checks++; if (y !== 32'h33) begin errors++; $display("[TB] FAIL upd_y got %h exp %h", y, 32'h33); end
  endtask

  task automatic test_latest_wins();
    req = 1'b1; s = 2'd1;
    step();
    s = 2'd3;
    step();
    req = 1'b0;
    checks++; if (sel !== 2'd2) begin errors++; $display("[TB] FAIL latest_sel_pre got %0d exp 2", sel); end
    upd = 1'b1;
    step();
    upd = 1'b0;
    checks++; if (sel !== 2'd3) begin errors++; $display("[TB] FAIL latest_sel got %0d exp 3", sel); end
    step();
    checks++; if (y !== 32'h44) begin errors++; $display("[TB] FAIL latest_y got %h exp %h", y, 32'h44); end
    upd = 1'b1;
    step();
    upd = 1'b0;
    checks++; if (sel !== 2'd3) begin errors++; $display("[TB] FAIL idle_upd_sel got %0d exp 3", sel); end
    checks++; if (pend !== 1'b0) begin errors++; $display("[TB] FAIL idle_upd_pend got %b exp 0", pend); end
  endtask

  task automatic test_simultaneous();
    req = 1'b1; s = 2'd1;
    step();
    checks++; if (pend !== 1'b1) begin errors++; $display("[TB] FAIL sim_pre_pend got %b exp 1", pend); end
    s = 2'd0; upd = 1'b1;
    step();
    req = 1'b0; upd = 1'b0;
    checks++; if (sel !== 2'd0) begin errors++; $display("[TB] FAIL sim_sel got %0d exp 0", sel); end
    checks++; if (pend !== 1'b0) begin errors++; $display("[TB] FAIL sim_pend got %b exp 0", pend); end
    step();
    checks++; if (y !== 32'h11) begin errors++; $display("[TB] FAIL sim_y got %h exp %h", y, 32'h11); end
  endtask

  task automatic test_hold_and_reset();
    en = 1'b0;
    d[31:0] = 32'hAA;
    step(); step();
    checks++; if (y !== 32'h11) begin errors++; $display("[TB] FAIL hold_y got %h exp %h", y, 32'h11); end
    en = 1'b1;
    step();
    checks++; if (y !== 32'hAA) begin errors++; $display("[TB] FAIL en_y got %h exp %h", y, 32'hAA); end
    // Switch while disabled: shows up at the first enabled edge.
    en = 1'b0; req = 1'b1; s = 2'd2;
    step();
    req = 1'b0; upd = 1'b1;
    step();
    upd = 1'b0;
    step();
    checks++; if (sel !== 2'd2) begin errors++; $display("[TB] FAIL dis_sel got %0d exp 2", sel); end
    checks++; if (y !== 32'hAA) begin errors++; $display("[TB] FAIL dis_y got %h exp %h", y, 32'hAA); end
    en = 1'b1;
    step();
    checks++; if (y !== 32'h33) begin errors++; $display("[TB] FAIL reen_y got %h exp %h", y, 32'h33); end
    req = 1'b1; s = 2'd1;
    step();
    req = 1'b0;
    // Reset asserted between edges must clear outputs immediately.
    #2 rst_n = 1'b0;
    #1;
    checks++; if (y !== 32'h0) begin errors++; $display("[TB] FAIL arst_y got %h exp %h", y, 32'h0); end
    checks++; if (sel !== 2'd0) begin errors++; $display("[TB] FAIL arst_sel got %0d exp 0", sel); end
    checks++; if (pend !== 1'b0) begin errors++; $display("[TB] FAIL arst_pend got %b exp 0", pend); end
    step();
    rst_n = 1'b1;
    upd = 1'b1;
    step();
    upd = 1'b0;
    checks++; if (sel !== 2'd0) begin errors++; $display("[TB] FAIL arst_discard_sel got %0d exp 0", sel); end
  endtask

  task automatic test_out_of_range();
    req3 = 1'b1; s3 = 2'd3;
    step();
    req3 = 1'b0;
    checks++; if (err3 !== 1'b1) begin errors++; $display("[TB] FAIL oor_err got %b exp 1", err3); end
    checks++; if (pend3 !== 1'b0) begin errors++; $display("[TB] FAIL oor_pend got %b exp 0", pend3); end
    upd3 = 1'b1;
    step();
    upd3 = 1'b0;
    checks++; if (err3 !== 1'b0) begin errors++; $display("[TB] FAIL oor_err_clr got %b exp 0", err3); end
    checks++; if (sel3 !== 2'd0) begin errors++; $display("[TB] FAIL oor_sel got %0d exp 0", sel3); end
    // Invalid request together with update commits the older pending value.
    req3 = 1'b1; s3 = 2'd1;
    step();
    s3 = 2'd3; upd3 = 1'b1;
    step();
    req3 = 1'b0; upd3 = 1'b0;
    checks++; if (err3 !== 1'b1) begin errors++; $display("[TB] FAIL oor_sim_err got %b exp 1", err3); end
    checks++; if (sel3 !== 2'd1) begin errors++; $display("[TB] FAIL oor_sim_sel got %0d exp 1", sel3); end
    checks++; if (pend3 !== 1'b0) begin errors++; $display("[TB] FAIL oor_sim_pend got %b exp 0", pend3); end
    // Highest valid channel of the N=3 instance.
    req3 = 1'b1; s3 = 2'd2; upd3 = 1'b1;
    step();
    req3 = 1'b0; upd3 = 1'b0;
    checks++; if (sel3 !== 2'd2) begin errors++; $display("[TB] FAIL top_sel got %0d exp 2", sel3); end
    checks++; if (err3 !== 1'b0) begin errors++; $display("[TB] FAIL top_err got %b exp 0", err3); end
    step();
    checks++; if (y3 !== 32'h33) begin errors++; $display("[TB] FAIL top_y got %h exp %h", y3, 32'h33); end
  endtask

  initial begin
    test_reset();
    test_deferred();
    test_latest_wins();
    test_simultaneous();
    test_hold_and_reset();
    test_out_of_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
